// File: rtl/conv1_pkg.sv
// Shared constants, state encoding and window/filter matrix type for the
// 3x3 convolution MAC.
package conv1_pkg;

    localparam int DATA_W  = 8;
    localparam int PROD_W  = 16;
    localparam int ACC_W   = 20;
    localparam int OUT_DIM = 6;
    localparam int WIN_DIM = 3;

    localparam int ROW_W   = PROD_W + 2;
    localparam int NUM_WIN = OUT_DIM * OUT_DIM;
    localparam int CNT_W   = 6;
    localparam int COORD_W = 3;
    localparam int SAT_MAX = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } conv1_state_e;

    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][DATA_W-1:0] mat_t;

endpackage

// File: rtl/conv1_mac_if.sv
// Start/filter, window stream and result stream of the convolution MAC.
// The master side drives start and windows; the slave side is the MAC.
interface conv1_mac_if;

    logic                              start;
    conv1_pkg::mat_t                   filt_in;
    logic                              win_valid;
    conv1_pkg::mat_t                   win_matrix;
    logic                              win_ready;
    logic                              out_valid;
    logic [conv1_pkg::ACC_W-1:0]       out_data;
    logic [conv1_pkg::COORD_W-1:0]     out_row;
    logic [conv1_pkg::COORD_W-1:0]     out_col;
    logic                              frame_done;

    modport master (
        output start, filt_in, win_valid, win_matrix,
        input  win_ready, out_valid, out_data, out_row, out_col, frame_done
    );

    modport slave (
        input  start, filt_in, win_valid, win_matrix,
        output win_ready, out_valid, out_data, out_row, out_col, frame_done
    );

endinterface

// File: rtl/conv1_mac_mult.sv
// Unsigned 8x8 -> 16 bit multiplier used for each filter tap.
module conv1_mac_mult
    import conv1_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/conv1_mac.sv
// 3x3 convolution MAC: filter capture, 36-window frame control and a
// 3-stage product/row-sum/total pipeline. CONV1_SAT_EN clamps results to 255.
module conv1_mac
    import conv1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    conv1_mac_if.slave  bus
);

    conv1_state_e state_reg, state_next;
    mat_t         filt_reg;
    logic [CNT_W-1:0] in_cnt_reg;

    logic [WIN_DIM-1:0][WIN_DIM-1:0][PROD_W-1:0] prod_next, prod_reg;
    logic [WIN_DIM-1:0][ROW_W-1:0]               row_sum_next, row_sum_reg;
    logic [ACC_W-1:0]                            sum_next, sum_reg;
    logic v1_reg, v2_reg, v3_reg;

    logic [COORD_W-1:0] row_reg, col_reg;
    logic               frame_done_reg;

    logic accept, last_accept, last_result, col_wrap;

    assign accept      = bus.win_valid && (state_reg == RUN);
    assign last_accept = accept && (in_cnt_reg == CNT_W'(NUM_WIN - 1));
    assign col_wrap    = (col_reg == COORD_W'(OUT_DIM - 1));
    assign last_result = v3_reg && col_wrap && (row_reg == COORD_W'(OUT_DIM - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start)   state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (last_result) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            filt_reg   <= '0;
            in_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // The filter is only captured on a start that actually arms a frame.
            if (state_reg == IDLE && bus.start)
                filt_reg <= bus.filt_in;
            if (accept)
                in_cnt_reg <= last_accept ? '0 : in_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < WIN_DIM; gj++) begin : g_col
            conv1_mac_mult u_mult (
                .a (filt_reg[gi][gj]),
                .b (bus.win_matrix[gi][gj]),
                .p (prod_next[gi][gj])
            );
        end
    end

    always_comb begin
        row_sum_next = '0;
        for (int i = 0; i < WIN_DIM; i++)
            for (int j = 0; j < WIN_DIM; j++)
                row_sum_next[i] = row_sum_next[i] + ROW_W'(prod_reg[i][j]);
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < WIN_DIM; i++)
            sum_next = sum_next + ACC_W'(row_sum_reg[i]);
    end

    // Data registers load every cycle; the valid bits alone qualify them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_reg    <= '0;
            row_sum_reg <= '0;
            sum_reg     <= '0;
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            v3_reg      <= 1'b0;
        end else begin
            prod_reg    <= prod_next;
            row_sum_reg <= row_sum_next;
            sum_reg     <= sum_next;
            v1_reg      <= accept;
            v2_reg      <= v1_reg;
            v3_reg      <= v2_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg        <= '0;
            col_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= last_result;
            if (v3_reg) begin
                col_reg <= col_wrap ? '0 : col_reg + 1'b1;
                if (col_wrap)
                    row_reg <= (row_reg == COORD_W'(OUT_DIM - 1)) ? '0 : row_reg + 1'b1;
            end
        end
    end

    assign bus.win_ready  = (state_reg == RUN);
    assign bus.out_valid  = v3_reg;
    assign bus.out_row    = row_reg;
    assign bus.out_col    = col_reg;
    assign bus.frame_done = frame_done_reg;

`ifdef CONV1_SAT_EN
    assign bus.out_data = (sum_reg > ACC_W'(SAT_MAX)) ? ACC_W'(SAT_MAX) : sum_reg;
`else
    assign bus.out_data = sum_reg;
`endif

endmodule

// File: tb/tb_conv1_mac.sv
// Self-checking bench for conv1_mac: a cycle-scheduled reference model plus
// table-driven constant frames and hand-written corner-case sequences.
module tb_conv1_mac;
    import conv1_pkg::*;

    typedef struct {
        int f;
        int w;
        int exp_full;
        int exp_sat;
    } vec_t;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv1_mac_if bus();

    conv1_mac dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: frame mode and results scheduled by cycle slot.
    int   m_mode  = M_IDLE;
    int   m_acc   = 0;
    int   m_drain = 0;
    mat_t m_filt;
    logic sch_v  [8];
    logic sch_fd [8];
    int   sch_d  [8];
    int   sch_r  [8];
    int   sch_c  [8];

    int res_cnt  = 0;
    int done_cnt = 0;
    int res_data [36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input mat_t f, input mat_t w);
        int s;
        s = 0;
        for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++)
                s += int'(f[p][q]) * int'(w[p][q]);
        return s;
    endfunction

    function automatic int exp_out(input int s);
`ifdef CONV1_SAT_EN
        return (s > 255) ? 255 : s;
`else
        return s;
`endif
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++)
                m[p][q] = 8'(v);
        return m;
    endfunction

    // Window of the feature map a[i][j] = i + j anchored at (r, c).
    function automatic mat_t win_at(input int r, input int c);
        mat_t m;
        for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++)
                m[p][q] = 8'(r + c + p + q);
        return m;
    endfunction

    function automatic mat_t filt_pq();
        mat_t m;
        for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++)
                m[p][q] = 8'(p + q);
        return m;
    endfunction

    always @(negedge clk) begin
        int s;
        int t;
        s = cyc % 8;
        if (reset) begin
            m_mode = M_IDLE;
            m_acc  = 0;
            for (int i = 0; i < 8; i++) begin
                sch_v[i]  = 1'b0;
                sch_fd[i] = 1'b0;
            end
            chk("reset_out_data", 32'(bus.out_data), 32'd0);
            chk("reset_out_row",  32'(bus.out_row),  32'd0);
            chk("reset_out_col",  32'(bus.out_col),  32'd0);
        end
        if (m_mode == M_DRAIN) begin
            m_drain--;
            if (m_drain == 0) m_mode = M_IDLE;
        end
        chk("win_ready", 32'(bus.win_ready), 32'(m_mode == M_RUN));
        chk("out_valid", 32'(bus.out_valid), 32'(sch_v[s]));
        if (sch_v[s]) begin
            chk("out_data", 32'(bus.out_data), 32'(sch_d[s]));
            chk("out_row",  32'(bus.out_row),  32'(sch_r[s]));
            chk("out_col",  32'(bus.out_col),  32'(sch_c[s]));
        end
        chk("frame_done", 32'(bus.frame_done), 32'(sch_fd[s]));
        if (bus.out_valid === 1'b1) begin
            $display("result row=%0d col=%0d data=%0d", bus.out_row, bus.out_col, bus.out_data);
            if (res_cnt < 36) res_data[res_cnt] = int'(bus.out_data);
            res_cnt++;
        end
        if (bus.frame_done === 1'b1) done_cnt++;
        sch_v[s]  = 1'b0;
        sch_fd[s] = 1'b0;
        if (!reset) begin
            if (m_mode == M_IDLE && bus.start) begin
                m_filt = bus.filt_in;
                m_mode = M_RUN;
                m_acc  = 0;
            end else if (m_mode == M_RUN && bus.win_valid) begin
                t = (s + 3) % 8;
                sch_v[t] = 1'b1;
                sch_d[t] = exp_out(dot(m_filt, bus.win_matrix));
                sch_r[t] = m_acc / 6;
                sch_c[t] = m_acc % 6;
                m_acc++;
                if (m_acc == 36) begin
                    sch_fd[(s + 4) % 8] = 1'b1;
                    m_mode  = M_DRAIN;
                    m_drain = 4;
                end
            end
        end
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input mat_t f);
        res_cnt     = 0;
        done_cnt    = 0;
        bus.filt_in = f;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic send(input mat_t w, input logic v);
        bus.win_matrix = w;
        bus.win_valid  = v;
        step();
        bus.win_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(done_cnt), 32'd1);
        repeat (3) step();
    endtask

    vec_t vecs [6];

    initial begin
        int k;
        vecs[0] = '{f: 255, w: 255, exp_full: 585225, exp_sat: 255};
        vecs[1] = '{f: 1,   w: 1,   exp_full: 9,      exp_sat: 9};
        vecs[2] = '{f: 0,   w: 200, exp_full: 0,      exp_sat: 0};
        vecs[3] = '{f: 2,   w: 3,   exp_full: 54,     exp_sat: 54};
        vecs[4] = '{f: 17,  w: 15,  exp_full: 2295,   exp_sat: 255};
        vecs[5] = '{f: 10,  w: 2,   exp_full: 180,    exp_sat: 180};

        bus.start      = 1'b0;
        bus.filt_in    = '0;
        bus.win_valid  = 1'b0;
        bus.win_matrix = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Windows offered while idle are not accepted.
        bus.win_matrix = fill(7);
        bus.win_valid  = 1'b1;
        repeat (5) step();
        bus.win_valid  = 1'b0;
        chk("idle_no_results", 32'(res_cnt), 32'd0);

        // Reference frame back-to-back, then valid held after the last accept.
        start_frame(filt_pq());
        for (int i = 0; i < 36; i++) send(win_at(i / 6, i % 6), 1'b1);
        bus.win_valid = 1'b1;
        repeat (3) step();
        bus.win_valid = 1'b0;
        wait_done("ref_frame_done", 20);
        chk("ref_count", 32'(res_cnt),     32'd36);
        chk("ref_00",    32'(res_data[0]),  32'(exp_out(48)));
        chk("ref_11",    32'(res_data[7]),  32'(exp_out(84)));
        chk("ref_55",    32'(res_data[35]), 32'(exp_out(228)));

        // Alternating win_valid.
        start_frame(filt_pq());
        k = 0;
        for (int i = 0; i < 72; i++) begin
            send(win_at(k / 6, k % 6), (i % 2) == 0);
            if ((i % 2) == 0) k++;
        end
        wait_done("toggle_frame_done", 20);
        chk("toggle_count", 32'(res_cnt),     32'd36);
        chk("toggle_55",    32'(res_data[35]), 32'(exp_out(228)));

        // Start re-asserted during RUN with a different filter is ignored.
        start_frame(filt_pq());
        for (int i = 0; i < 36; i++) begin
            if (i == 10) begin
                bus.start   = 1'b1;
                bus.filt_in = fill(1);
            end
            send(win_at(i / 6, i % 6), 1'b1);
            bus.start = 1'b0;
        end
        wait_done("restart_frame_done", 20);
        chk("restart_14", 32'(res_data[10]), 32'(exp_out(138)));
        chk("restart_55", 32'(res_data[35]), 32'(exp_out(228)));

        // Reset mid-frame with results in flight.
        start_frame(filt_pq());
        for (int i = 0; i < 10; i++) send(win_at(i / 6, i % 6), 1'b1);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        res_cnt  = 0;
        done_cnt = 0;
        repeat (6) step();
        chk("reset_no_stale", 32'(res_cnt + done_cnt), 32'd0);
        start_frame(fill(1));
        send(fill(1), 1'b1);
        repeat (4) step();
        chk("reset_first_cnt",  32'(res_cnt),     32'd1);
        chk("reset_first_data", 32'(res_data[0]), 32'd9);
        for (int i = 1; i < 36; i++) send(fill(1), 1'b1);
        wait_done("reset_frame_done", 20);

        // Constant-valued frames from the vector table.
        foreach (vecs[v]) begin
            start_frame(fill(vecs[v].f));
            for (int i = 0; i < 36; i++) send(fill(vecs[v].w), 1'b1);
            wait_done("vec_frame_done", 20);
            chk("vec_count", 32'(res_cnt), 32'd36);
`ifdef CONV1_SAT_EN
            chk("vec_first", 32'(res_data[0]),  32'(vecs[v].exp_sat));
            chk("vec_last",  32'(res_data[35]), 32'(vecs[v].exp_sat));
`else
            chk("vec_first", 32'(res_data[0]),  32'(vecs[v].exp_full));
            chk("vec_last",  32'(res_data[35]), 32'(vecs[v].exp_full));
`endif
        end

        // Random filters, windows, gaps and stray start pulses.
        for (int fr = 0; fr < 4; fr++) begin
            mat_t rf;
            mat_t rw;
            for (int p = 0; p < 3; p++)
                for (int q = 0; q < 3; q++)
                    rf[p][q] = 8'($urandom);
            start_frame(rf);
            k = 0;
            while (k < 36) begin
                logic vv;
                for (int p = 0; p < 3; p++)
                    for (int q = 0; q < 3; q++)
                        rw[p][q] = 8'($urandom);
                vv = ($urandom_range(0, 3) != 0);
                bus.start   = ($urandom_range(0, 15) == 0);
                bus.filt_in = fill(int'($urandom_range(0, 255)));
                send(rw, vv);
                bus.start = 1'b0;
                if (vv) k++;
            end
            wait_done("rand_frame_done", 20);
            chk("rand_count", 32'(res_cnt), 32'd36);
        end

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv1_mac.md
CONV1_MAC -- requirements
Module: conv1_mac

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse; captures filter and arms a frame.
REQ-004 filt_in  input  8b x [2:0][2:0]  unsigned 3x3 filter, sampled only on accepted start.
REQ-005 win_valid  input  1  upstream 3x3 window is valid this cycle.
REQ-006 win_matrix  input  8b x [2:0][2:0]  unsigned 3x3 window from the window-generator stage.
REQ-007 win_ready  output  1  block accepts a window this cycle.
REQ-008 out_valid  output  1  out_data/out_row/out_col are valid for this cycle only; no downstream backpressure.
REQ-009 out_data  output  20  convolution result.
REQ-010 out_row, out_col  output  3 each  output-map coordinates, 0..5.
REQ-011 frame_done  output  1  one-cycle pulse after the 36th result.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-013 IDLE->RUN on start; filt_in latched into an internal filter register on that edge.
REQ-014 In IDLE, start SHALL be the only accepted event; win_valid is ignored and win_ready=0.
REQ-015 start while in RUN or DRAIN SHALL be ignored; the filter register stays unchanged.
REQ-016 win_ready SHALL be 1 in RUN only; a window is accepted when win_valid && win_ready.
REQ-017 Accepted windows SHALL be counted by an input counter 0..35; the 36th accept moves RUN->DRAIN.
REQ-018 Datapath SHALL be a 3-stage pipeline: S1 registers nine 16-bit products filter[p][q]*win[p][q]; S2 registers three row sums (18b); S3 registers the full sum (20b).
REQ-019 out_valid SHALL assert exactly 3 cycles after the accepting edge, one result per accepted window, in accept order.
REQ-020 All arithmetic SHALL be unsigned and zero-extended; 20 bits hold the maximum 9*255*255=585225 with no overflow.
REQ-021 out_col SHALL advance 0..5 per valid result and wrap to 0, incrementing out_row; row 5 col 5 is the last result.
REQ-022 frame_done SHALL pulse in the cycle after the out_valid carrying (5,5); DRAIN->IDLE on that same edge.
REQ-023 Gaps in win_valid SHALL produce matching gaps in out_valid; pipeline valid bits track each stage.

Reset
REQ-024 reset SHALL force IDLE, zero all counters, filter, and pipeline registers and valid bits, immediately (async).
REQ-025 During reset: win_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0.
REQ-026 Reset mid-frame SHALL discard in-flight results; no out_valid or frame_done for that frame after release.

Configuration
REQ-027 With CONV1_SAT_EN defined, out_data SHALL equal min(sum,255), zero-extended to 20b; latency unchanged.
REQ-028 Without CONV1_SAT_EN, out_data SHALL be the full 20-bit sum.

Structure
REQ-029 Package conv1_pkg SHALL hold DATA_W=8, PROD_W=16, ACC_W=20, OUT_DIM=6, WIN_DIM=3 and the state enum typedef.
REQ-030 The existing mult sub-module (8x8->16 unsigned) SHALL be instantiated nine times for S1; the adder tree stays in conv1_mac.

Verification
REQ-031 Feature map a[i][j]=i+j, filter f[p][q]=p+q, start, then 36 windows back-to-back -> result (0,0)=48, (r,c)=48+18*(r+c), (5,5)=228, frame_done one cycle after (5,5).
REQ-032 All windows and filter 255, CONV1_SAT_EN off -> every out_data=585225; with the macro on -> 255.
REQ-033 win_valid toggling 1,0,1,0 -> out_valid follows the same pattern delayed 3 cycles; frame_done after 36 results.
REQ-034 start reasserted with filter all 1 during RUN -> ignored; results still match REQ-031 values.
REQ-035 reset asserted after 10 windows, released, new start with filter all 1 and a window of all 1 -> first out_data=9 at (0,0), no stale outputs.
REQ-036 win_valid held high in IDLE and after the 36th accept -> win_ready=0, no extra results.
